// File: rtl/dsss_pkg.sv
// Shared DSSS transmit definitions: carrier format, period geometry and
// the modulator state encoding.
package dsss_pkg;

   localparam int CAR_W              = 8;
   localparam int SAMPLES_PER_PERIOD = 36;
   localparam int PERIODS_PER_CHIP   = 1;

   typedef logic signed [CAR_W-1:0] car_sample_t;

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      RUN
   } mod_state_e;

endpackage

// File: rtl/bpsk_chip_modulator_if.sv
// Chip stream handshake between the PN spreader (master) and the modulator.
interface bpsk_chip_modulator_if;
   logic chip_in;
   logic chip_valid;
   logic chip_ready;

   modport master (output chip_in, output chip_valid, input chip_ready);
   modport slave  (input chip_in, input chip_valid, output chip_ready);
endinterface

// File: rtl/bpsk_chip_modulator_tracker.sv
// Carrier period tracker: counts samples and periods against car_sof,
// decodes chip boundaries and flags carrier framing faults.
module carrier_period_tracker
   import dsss_pkg::*;
#(
   parameter int SPP = 36,
   parameter int PPC = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic in_sync,
   input  logic in_run,
   input  logic car_sof,
   output logic boundary,
   output logic sync_fault
);

   localparam int SW = (SPP > 1) ? $clog2(SPP) : 1;
   localparam int PW = (PPC > 1) ? $clog2(PPC) : 1;

   // samp_cnt holds the index of the previous sample, so it reads SPP-1
   // on a correctly spaced car_sof.
   logic [SW-1:0] samp_cnt;
   logic [PW-1:0] per_cnt;
   logic          last_samp;
   logic          last_per;

   assign last_samp  = (samp_cnt == SW'(SPP - 1));
   assign last_per   = (per_cnt == PW'(PPC - 1));
   assign sync_fault = in_run & (car_sof ^ last_samp);
   assign boundary   = car_sof & (in_sync | (in_run & last_per));

   // Counters run only while locked (or locking); any fault or drop of
   // lock returns them to zero.
   always_ff @(posedge clk) begin
      if (rst || !en || sync_fault || !(in_run || (in_sync && car_sof))) begin
         samp_cnt <= '0;
         per_cnt  <= '0;
      end else if (car_sof) begin
         samp_cnt <= '0;
         per_cnt  <= boundary ? '0 : per_cnt + PW'(1);
      end else begin
         samp_cnt <= samp_cnt + SW'(1);
      end
   end

endmodule

// File: rtl/bpsk_chip_modulator.sv
// BPSK chip modulator: multiplies the carrier by +1/-1 per chip, switching
// chips only at carrier period boundaries for phase-continuous symbols.
module bpsk_chip_modulator #(
   parameter int CAR_W              = dsss_pkg::CAR_W,
   parameter int SAMPLES_PER_PERIOD = dsss_pkg::SAMPLES_PER_PERIOD,
   parameter int PERIODS_PER_CHIP   = dsss_pkg::PERIODS_PER_CHIP
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic signed [CAR_W-1:0]   car_in,
   input  logic                      car_sof,
   bpsk_chip_modulator_if.slave      chip,
   output logic signed [CAR_W-1:0]   mod_out,
   output logic                      mod_valid,
   output logic                      underrun,
   output logic                      sync_err
);
   import dsss_pkg::*;

   localparam logic signed [CAR_W-1:0] MIN_V = {1'b1, {(CAR_W-1){1'b0}}};
   localparam logic signed [CAR_W-1:0] MAX_V = {1'b0, {(CAR_W-1){1'b1}}};

   mod_state_e               state;
   logic                     chip_reg;
   logic                     chip_active;
   logic                     boundary;
   logic                     sync_fault;
   logic                     in_sync;
   logic                     in_run;
   logic                     take;
   logic                     take_valid;
   logic                     eff_active;
   logic                     eff_chip;
   logic                     live;
   logic signed [CAR_W-1:0]  mod_next;

   assign in_sync = (state == SYNC);
   assign in_run  = (state == RUN);

   carrier_period_tracker #(
      .SPP (SAMPLES_PER_PERIOD),
      .PPC (PERIODS_PER_CHIP)
   ) u_tracker (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .in_sync    (in_sync),
      .in_run     (in_run),
      .car_sof    (car_sof),
      .boundary   (boundary),
      .sync_fault (sync_fault)
   );

   // A chip is taken only at a clean boundary while enabled; a framing
   // fault on the same cycle wins over acceptance.
   assign chip.chip_ready = ~rst & en & boundary & ~sync_fault;
   assign take       = chip.chip_ready;
   assign take_valid = take & chip.chip_valid;

   // The newly accepted chip already modulates the car_sof sample.
   assign eff_active = take ? chip.chip_valid : chip_active;
   assign eff_chip   = take_valid ? chip.chip_in : chip_reg;
   assign live       = en & (in_run | (in_sync & car_sof));

   // Sign select with saturating negation of the most negative sample.
   always_comb begin
      mod_next = '0;
      if (live && eff_active) begin
         if (eff_chip)            mod_next = car_in;
         else if (car_in == MIN_V) mod_next = MAX_V;
         else                     mod_next = -car_in;
      end
   end

   // FSM, chip register and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         chip_reg    <= 1'b0;
         chip_active <= 1'b0;
         mod_out     <= '0;
         mod_valid   <= 1'b0;
         underrun    <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         mod_out   <= mod_next;
         mod_valid <= live;
         underrun  <= take & ~chip.chip_valid;
         sync_err  <= en & sync_fault;
         if (!en) begin
            state       <= IDLE;
            chip_active <= 1'b0;
         end else begin
            case (state)
               IDLE:    state <= SYNC;
               SYNC:    if (car_sof) state <= RUN;
               RUN:     if (sync_fault) state <= SYNC;
               default: state <= IDLE;
            endcase
            if (sync_fault) begin
               chip_active <= 1'b0;
            end else if (take) begin
               chip_active <= chip.chip_valid;
               if (chip.chip_valid) chip_reg <= chip.chip_in;
            end
         end
      end
   end

endmodule

// File: tb/tb_bpsk_chip_modulator.sv
// Bench for bpsk_chip_modulator: two instances (1 and 3 periods per chip)
// share the carrier; each has its own chip source queue and scoreboard.
module tb_bpsk_chip_modulator;
   import dsss_pkg::*;

   typedef struct packed {
      logic signed [7:0] out;
      logic              vld;
      logic              ur;
      logic              se;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   car_sample_t car_in;
   logic        car_sof;

   logic              cvd [2];
   logic              cid [2];
   logic              rdy [2];
   logic signed [7:0] mo  [2];
   logic              mv  [2];
   logic              ur  [2];
   logic              se  [2];

   bpsk_chip_modulator_if cif1 ();
   bpsk_chip_modulator_if cif3 ();

   assign cif1.chip_valid = cvd[0];
   assign cif1.chip_in    = cid[0];
   assign cif3.chip_valid = cvd[1];
   assign cif3.chip_in    = cid[1];
   assign rdy[0] = cif1.chip_ready;
   assign rdy[1] = cif3.chip_ready;

   always #5 clk = ~clk;

   bpsk_chip_modulator #(.PERIODS_PER_CHIP(1)) dut1 (
      .clk (clk), .rst (rst), .en (en), .car_in (car_in), .car_sof (car_sof),
      .chip (cif1.slave), .mod_out (mo[0]), .mod_valid (mv[0]),
      .underrun (ur[0]), .sync_err (se[0])
   );

   bpsk_chip_modulator #(.PERIODS_PER_CHIP(3)) dut3 (
      .clk (clk), .rst (rst), .en (en), .car_in (car_in), .car_sof (car_sof),
      .chip (cif3.slave), .mod_out (mo[1]), .mod_valid (mv[1]),
      .underrun (ur[1]), .sync_err (se[1])
   );

   int   n_assert = 0;
   int   n_fail   = 0;
   int   car_tab [36];
   int   k;
   bit   early;
   bit   use_ovr;
   int   car_ovr;
   bit   src [2][$];
   exp_t sb  [2][$];
   int   mst [2];
   bit   act [2];
   bit   chp [2];
   int   pcnt [2];
   int   ppc [2] = '{1, 3};

   task automatic chk(input string tag, input logic signed [31:0] got,
                      input logic signed [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int fexp(input bit a, input bit c, input int car);
      if (!a) return 0;
      if (c) return car;
      return (-car > 127) ? 127 : -car;
   endfunction

   // One carrier sample: drive, check ready, predict next outputs, clock,
   // then pop and compare.
   task automatic tick();
      exp_t e;
      int   car;
      bit   sof;
      bit   take;
      car     = use_ovr ? car_ovr : car_tab[k];
      sof     = (k == 0) || early;
      car_in  = 8'(car);
      car_sof = sof;
      for (int d = 0; d < 2; d++) begin
         cvd[d] = (src[d].size() > 0);
         cid[d] = cvd[d] ? src[d][0] : 1'b0;
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         e    = '0;
         take = 1'b0;
         if (rst || !en) begin
            mst[d] = 0; act[d] = 1'b0; pcnt[d] = 0;
         end else begin
            case (mst[d])
               0: mst[d] = 1;
               1: if (sof) take = 1'b1;
               default: begin
                  if (early) begin
                     e.vld = 1'b1; e.se = 1'b1;
                     e.out = 8'(fexp(act[d], chp[d], car));
                     act[d] = 1'b0; mst[d] = 1;
                  end else begin
                     if (sof) begin
                        if (pcnt[d] == ppc[d] - 1) take = 1'b1;
                        else pcnt[d]++;
                     end
                     if (!take) begin
                        e.vld = 1'b1;
                        e.out = 8'(fexp(act[d], chp[d], car));
                     end
                  end
               end
            endcase
         end
         if (take) begin
            pcnt[d] = 0; mst[d] = 2;
            if (cvd[d]) begin
               act[d] = 1'b1; chp[d] = src[d].pop_front();
            end else begin
               act[d] = 1'b0; e.ur = 1'b1;
            end
            e.vld = 1'b1;
            e.out = 8'(fexp(act[d], chp[d], car));
         end
         chk($sformatf("ready[%0d] k=%0d", d, k), 32'(rdy[d]), 32'(take));
         sb[d].push_back(e);
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         e = sb[d].pop_front();
         chk($sformatf("mod_out[%0d] k=%0d", d, k), 32'(mo[d]), 32'(e.out));
         chk($sformatf("mod_valid[%0d] k=%0d", d, k), 32'(mv[d]), 32'(e.vld));
         chk($sformatf("underrun[%0d] k=%0d", d, k), 32'(ur[d]), 32'(e.ur));
         chk($sformatf("sync_err[%0d] k=%0d", d, k), 32'(se[d]), 32'(e.se));
      end
      k = (k + 1) % 36;
   endtask

   task automatic to_sof();
      for (int i = 0; i < 36 && k != 0; i++) tick();
   endtask

   initial begin
      for (int i = 0; i < 36; i++) begin
         real r;
         r = 64.0 * $sin(2.0 * 3.14159265358979 * i / 36.0);
         car_tab[i] = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
      end
      for (int d = 0; d < 2; d++) begin
         mst[d] = 0; act[d] = 1'b0; chp[d] = 1'b0; pcnt[d] = 0;
      end
      rst = 1'b1; en = 1'b0; early = 1'b0; use_ovr = 1'b0; car_ovr = 0; k = 30;

      // Reset state, then enable and lock on the first car_sof.
      tick(); tick();
      rst = 1'b0; en = 1'b1;
      src[0].push_back(1'b1); src[0].push_back(1'b0); src[0].push_back(1'b1);
      src[1].push_back(1'b1); src[1].push_back(1'b0); src[1].push_back(1'b1);
      to_sof();
      // Alternating chips, then an empty source at the 4th boundary.
      repeat (4 * 36) tick();
      src[0].push_back(1'b0); src[0].push_back(1'b1);
      // Resume; the 3-period instance takes its third chip at period 6.
      repeat (3 * 36) tick();

      // Early car_sof at sample 20 forces a relock with a fresh chip.
      src[0].push_back(1'b1);
      repeat (20) tick();
      src[0].push_back(1'b0); src[1].push_back(1'b1);
      early = 1'b1; tick(); early = 1'b0;
      to_sof();
      repeat (36) tick();

      // Drop enable mid-chip, re-enable, relock.
      repeat (10) tick();
      en = 1'b0; repeat (3) tick();
      en = 1'b1;
      src[0].push_back(1'b0); src[1].push_back(1'b0);
      to_sof();
      // Saturating negation of the most negative sample with chip 0.
      repeat (5) tick();
      use_ovr = 1'b1; car_ovr = -128; tick();
      car_ovr = 127; tick();
      use_ovr = 1'b0;
      repeat (5) tick();
      // Reset in the middle of RUN.
      rst = 1'b1; repeat (2) tick();
      rst = 1'b0; repeat (5) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
